// File: rtl/ifu_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_unit_if
// Brief    : Core-side fetch handshake and instruction-memory bus of the IFU.
// Revision : 1.0 - initial release
// ============================================================================
interface ifu_fetch_unit_if #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32,
    parameter int DATA_W = 64
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_pc;
    logic              fetch_ready;
    logic              flush;

    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_fault;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic              mem_resp_err;

    // master: core + instruction memory; slave: the fetch unit
    modport master (
        output fetch_req, fetch_pc, flush, inst_ready,
               mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        input  fetch_ready, inst_valid, inst, inst_pc, inst_fault,
               mem_req_valid, mem_req_addr
    );

    modport slave (
        input  fetch_req, fetch_pc, flush, inst_ready,
               mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        output fetch_ready, inst_valid, inst, inst_pc, inst_fault,
               mem_req_valid, mem_req_addr
    );
endinterface
`default_nettype wire

// File: rtl/ifu_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_unit
// Brief    : Instruction fetch unit, one outstanding aligned 64-bit read,
//            flush/redirect support. Optional IFU_MISALIGN_CHECK_EN faults
//            pc[1:0]!=0 without touching memory.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch_unit #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32,
    parameter int DATA_W = 2 * INST_W
) (
    input  logic               clk,
    input  logic               rst,
    ifu_fetch_unit_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_kill;
    logic [ADDR_W-1:0] r_pc;

    logic              w_accept;
    logic              w_misalign;
    logic [INST_W-1:0] w_instSel;

    assign bus.fetch_ready = (r_state == S_IDLE) && !bus.flush;
    assign w_accept        = bus.fetch_req && bus.fetch_ready;
    assign w_instSel       = r_pc[2] ? bus.mem_resp_data[DATA_W-1:INST_W]
                                     : bus.mem_resp_data[INST_W-1:0];

`ifdef IFU_MISALIGN_CHECK_EN
    assign w_misalign = (bus.fetch_pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_kill            <= 1'b0;
            r_pc              <= '0;
            bus.inst_valid    <= 1'b0;
            bus.inst          <= '0;
            bus.inst_pc       <= '0;
            bus.inst_fault    <= 1'b0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_pc <= bus.fetch_pc;
                        if (w_misalign) begin
                            r_state        <= S_HOLD;
                            bus.inst       <= '0;
                            bus.inst_fault <= 1'b1;
                            bus.inst_pc    <= bus.fetch_pc;
                            bus.inst_valid <= 1'b1;
                        end else begin
                            r_state           <= S_REQ;
                            bus.mem_req_valid <= 1'b1;
                            bus.mem_req_addr  <= {bus.fetch_pc[ADDR_W-1:3], 3'b000};
                        end
                    end
                end

                // Request cannot be withdrawn; a flush here only marks it for draining.
                S_REQ: begin
                    if (bus.flush) begin
                        r_kill <= 1'b1;
                    end
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        r_state           <= (r_kill || bus.flush) ? S_DRAIN : S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (bus.flush) begin
                        if (bus.mem_resp_valid) begin
                            r_state <= S_IDLE;
                            r_kill  <= 1'b0;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (bus.mem_resp_valid) begin
                        bus.inst       <= w_instSel;
                        bus.inst_fault <= bus.mem_resp_err;
                        bus.inst_pc    <= r_pc;
                        bus.inst_valid <= 1'b1;
                        r_state        <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (bus.flush || bus.inst_ready) begin
                        bus.inst_valid <= 1'b0;
                        r_state        <= S_IDLE;
                        r_kill         <= 1'b0;
                    end
                end

                S_DRAIN: begin
                    if (bus.mem_resp_valid) begin
                        r_state <= S_IDLE;
                        r_kill  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_kill  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch_unit
// Brief    : Directed + randomized bench for ifu_fetch_unit with a
//            transaction-level reference model and memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_unit;
    localparam int ADDR_W = 64;
    localparam int INST_W = 32;
    localparam int DATA_W = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifu_fetch_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DATA_W(DATA_W)) bus ();

    ifu_fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // memory responder knobs
    int          readyPct  = 100;
    int          delayMin  = 0;
    int          delayMax  = 0;
    logic        forceOn   = 1'b0;
    logic [63:0] forcedData = '0;
    logic        forcedErr = 1'b0;

    logic        memPending = 1'b0;
    int          memDelay   = 0;
    logic [63:0] memData;
    logic        memErr;

    initial begin
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.mem_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                memPending = 1'b0;
            end else if (bus.mem_resp_valid) begin
                memPending = 1'b0;
            end else if (bus.mem_req_valid && bus.mem_req_ready) begin
                memPending = 1'b1;
                memDelay   = int'($urandom_range(delayMax, delayMin));
                memData    = forceOn ? forcedData : {$urandom(), $urandom()};
                memErr     = forceOn ? forcedErr : ($urandom_range(7, 0) == 0);
            end
            @(posedge clk);
            #2;
            bus.mem_req_ready  = (int'($urandom_range(99, 0)) < readyPct);
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = {$urandom(), $urandom()};
            bus.mem_resp_err   = $urandom_range(1, 0) == 1;
            if (memPending) begin
                if (memDelay == 0) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data  = memData;
                    bus.mem_resp_err   = memErr;
                end else begin
                    memDelay--;
                end
            end
        end
    end

    // Reference model: tracks the single fetch transaction by its progress.
    logic        checkEn   = 1'b0;
    logic        mBusy     = 1'b0;
    logic        mReqDone  = 1'b0;
    logic        mRespDone = 1'b0;
    logic        mKilled   = 1'b0;
    logic [63:0] mPc       = '0;
    logic [31:0] mInst     = '0;
    logic        mFault    = 1'b0;

    always @(negedge clk) begin
        if (checkEn) begin
            checkEq("fetch_ready", bus.fetch_ready, !mBusy && !bus.flush);
            checkEq("mem_req_valid", bus.mem_req_valid, mBusy && !mReqDone);
            if (mBusy && !mReqDone)
                checkEq("mem_req_addr", bus.mem_req_addr, {mPc[63:3], 3'b000});
            checkEq("inst_valid", bus.inst_valid, mBusy && mRespDone && !mKilled);
            if (mBusy && mRespDone && !mKilled) begin
                checkEq("inst", bus.inst, mInst);
                checkEq("inst_pc", bus.inst_pc, mPc);
                checkEq("inst_fault", bus.inst_fault, mFault);
            end
        end

        if (rst) begin
            mBusy = 1'b0;
        end else if (!mBusy) begin
            if (bus.fetch_req && !bus.flush) begin
                mBusy = 1'b1; mPc = bus.fetch_pc;
                mReqDone = 1'b0; mRespDone = 1'b0; mKilled = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
                if (bus.fetch_pc[1:0] != 2'b00) begin
                    mReqDone = 1'b1; mRespDone = 1'b1; mInst = '0; mFault = 1'b1;
                end
`endif
            end
        end else if (mRespDone && !mKilled) begin
            if (bus.flush || bus.inst_ready) mBusy = 1'b0;
        end else begin
            if (bus.flush) mKilled = 1'b1;
            if (!mReqDone) begin
                if (bus.mem_req_ready) mReqDone = 1'b1;
            end else if (bus.mem_resp_valid) begin
                if (mKilled) begin
                    mBusy = 1'b0;
                end else begin
                    mRespDone = 1'b1;
                    mInst  = mPc[2] ? bus.mem_resp_data[63:32] : bus.mem_resp_data[31:0];
                    mFault = bus.mem_resp_err;
                end
            end
        end
    end

    // lat = index of the cycle where inst_valid is seen, accept cycle = 0
    task automatic fetchAndWait(input logic [63:0] pc, input int releaseAt,
                                output int lat, output logic [63:0] addrSeen, output logic sawReq);
        @(posedge clk); #1;
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = pc;
        @(posedge clk); #1;
        bus.fetch_req = 1'b0;
        addrSeen = bus.mem_req_addr;
        sawReq   = bus.mem_req_valid;
        lat = 1;
        while (!bus.inst_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (lat == releaseAt) readyPct = 100;
            sawReq |= bus.mem_req_valid;
        end
    endtask

    task automatic consume();
        bus.inst_ready = 1'b1;
        @(posedge clk); #1;
        bus.inst_ready = 1'b0;
    endtask

    int          lat;
    logic [63:0] addrSeen;
    logic        sawReq;

    initial begin
        rst = 1'b1;
        bus.fetch_req  = 1'b0;
        bus.fetch_pc   = '0;
        bus.flush      = 1'b0;
        bus.inst_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkEn = 1'b1;

        checkEq("rst_inst_valid", bus.inst_valid, 0);
        checkEq("rst_mem_req_valid", bus.mem_req_valid, 0);
        checkEq("rst_fetch_ready", bus.fetch_ready, 1);
        checkEq("rst_inst", bus.inst, 0);
        checkEq("rst_mem_req_addr", bus.mem_req_addr, 0);

        // basic fetch, upper word, minimum latency
        forceOn = 1'b1; forcedData = 64'h00100093_00000413; forcedErr = 1'b0;
        fetchAndWait(64'h8000_0004, 0, lat, addrSeen, sawReq);
        checkEq("basic_lat", lat, 3);
        checkEq("basic_inst", bus.inst, 64'h00100093);
        checkEq("basic_pc", bus.inst_pc, 64'h8000_0004);
        checkEq("basic_addr", addrSeen, 64'h8000_0000);

        // core stalls for 3 cycles in HOLD
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkEq("hold_fetch_ready", bus.fetch_ready, 0);
            checkEq("hold_inst", bus.inst, 64'h00100093);
            checkEq("hold_valid", bus.inst_valid, 1);
        end
        consume();
        checkEq("hold_release_valid", bus.inst_valid, 0);
        checkEq("hold_release_ready", bus.fetch_ready, 1);

        // memory back-pressure, lower word
        readyPct = 0;
        fetchAndWait(64'h8000_1000, 6, lat, addrSeen, sawReq);
        checkEq("bp_lat", lat, 8);
        checkEq("bp_inst", bus.inst, 64'h00000413);
        checkEq("bp_addr", addrSeen, 64'h8000_1000);
        consume();

        // flush while waiting for the response
        delayMin = 1; delayMax = 1; forcedData = 64'h0000_0000_dead_beef;
        @(posedge clk); #1; bus.fetch_req = 1'b1; bus.fetch_pc = 64'h8000_0010;
        @(posedge clk); #1; bus.fetch_req = 1'b0;
        @(posedge clk); #1; bus.flush = 1'b1;
        @(posedge clk); #1; bus.flush = 1'b0;
        checkEq("flush_drain_ready", bus.fetch_ready, 0);
        checkEq("flush_drain_valid", bus.inst_valid, 0);
        @(posedge clk); #1;
        checkEq("flush_idle_ready", bus.fetch_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkEq("flush_no_valid", bus.inst_valid, 0);
        end

        // memory error response
        delayMin = 0; delayMax = 0; forcedData = 64'h00100093_00000413; forcedErr = 1'b1;
        fetchAndWait(64'h8000_0020, 0, lat, addrSeen, sawReq);
        checkEq("err_lat", lat, 3);
        checkEq("err_fault", bus.inst_fault, 1);
        checkEq("err_inst", bus.inst, 64'h00000413);
        consume();
        forcedErr = 1'b0;

        // reset while in WAIT
        delayMin = 3; delayMax = 3;
        @(posedge clk); #1; bus.fetch_req = 1'b1; bus.fetch_pc = 64'h8000_0044;
        @(posedge clk); #1; bus.fetch_req = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        checkEq("rstw_inst_valid", bus.inst_valid, 0);
        checkEq("rstw_mem_req_valid", bus.mem_req_valid, 0);
        checkEq("rstw_inst", bus.inst, 0);
        checkEq("rstw_inst_pc", bus.inst_pc, 0);
        checkEq("rstw_fault", bus.inst_fault, 0);
        checkEq("rstw_addr", bus.mem_req_addr, 0);
        checkEq("rstw_fetch_ready", bus.fetch_ready, 1);
        repeat (5) @(posedge clk);
        #1;

        delayMin = 0; delayMax = 0;
`ifdef IFU_MISALIGN_CHECK_EN
        fetchAndWait(64'h8000_0002, 0, lat, addrSeen, sawReq);
        checkEq("mis_lat", lat, 1);
        checkEq("mis_no_req", sawReq, 0);
        checkEq("mis_fault", bus.inst_fault, 1);
        checkEq("mis_inst", bus.inst, 0);
        checkEq("mis_pc", bus.inst_pc, 64'h8000_0002);
`else
        fetchAndWait(64'h8000_0006, 0, lat, addrSeen, sawReq);
        checkEq("mis_lat", lat, 3);
        checkEq("mis_inst", bus.inst, 64'h00100093);
        checkEq("mis_fault", bus.inst_fault, 0);
        checkEq("mis_addr", addrSeen, 64'h8000_0000);
`endif
        consume();

        // randomized traffic, checked by the model
        forceOn = 1'b0; readyPct = 70; delayMin = 0; delayMax = 3;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            bus.fetch_req  = $urandom_range(99, 0) < 60;
            bus.fetch_pc   = {$urandom(), $urandom()};
            bus.flush      = $urandom_range(99, 0) < 8;
            bus.inst_ready = $urandom_range(99, 0) < 50;
            rst            = $urandom_range(999, 0) < 10;
        end
        @(posedge clk); #1;
        rst = 1'b0; bus.fetch_req = 1'b0; bus.flush = 1'b0; bus.inst_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
`default_nettype wire
